// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX FIFO, decoded at word address 002h-003h.
module uart_mmio #(
    parameter int ADDR_WIDTH = 10,
    parameter int BAUD_DIV   = 234,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_wr,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  rd_hit,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic                  tx_busy,
    output logic                  tx_overflow,
    output logic                  rx_valid
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    logic            hit, push_req, push, pop;
    logic [7:0]      fifo [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    tx_state_t       tx_state, tx_state_n;
    logic [BW-1:0]   tx_baud, tx_baud_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_shift, tx_shift_n;
    logic            tx_out_n;
    logic            rx_s1, rx_s;
    rx_state_t       rx_state, rx_state_n;
    logic [BW-1:0]   rx_baud, rx_baud_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shift, rx_shift_n, rx_last, rx_last_n;
    logic            rx_valid_n;
    logic            unused;

    assign hit      = mem_addr[ADDR_WIDTH-1:1] == (ADDR_WIDTH-1)'(1);
    assign push_req = mem_wr && hit;
    assign push     = push_req && (count < DEPTH || pop);
    assign tx_busy  = count != '0 || tx_state != TX_IDLE;
    assign unused   = ^{mem_addr[0], wr_data[15:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit      <= 1'b0;
            rd_data     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            rd_hit  <= hit;
            rd_data <= hit ? {8'hfe, rx_last} : 16'h0000;
            wr_ptr  <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count   <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push_req && !push)
                tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push)
            fifo[wr_ptr] <= wr_data[7:0];

    always_comb begin
        tx_state_n = tx_state;
        tx_baud_n  = tx_baud + BW'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_out_n   = uart_tx;
        pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_baud_n = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    tx_shift_n = fifo[rd_ptr];
                    tx_out_n   = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: if (tx_baud == BAUD_LAST) begin
                tx_baud_n  = '0;
                tx_bit_n   = '0;
                tx_out_n   = tx_shift[0];
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_baud == BAUD_LAST) begin
                tx_baud_n  = '0;
                tx_bit_n   = tx_bit + 3'd1;
                tx_shift_n = tx_shift >> 1;
                tx_out_n   = tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
                tx_state_n = tx_bit == 3'd7 ? TX_STOP : TX_DATA;
            end
            default: if (tx_baud == BAUD_LAST) begin
                // back-to-back frames: reload straight into START with no idle bit
                tx_baud_n  = '0;
                pop        = count != '0;
                tx_shift_n = count != '0 ? fifo[rd_ptr] : tx_shift;
                tx_out_n   = count == '0;
                tx_state_n = count != '0 ? TX_START : TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_baud  <= tx_baud_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_out_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_baud_n  = rx_baud + BW'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_last_n  = rx_last;
        rx_valid_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_baud_n  = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_START;
            end
            RX_START: if (rx_baud == HALF_LAST) begin
                rx_baud_n  = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_baud == BAUD_LAST) begin
                rx_baud_n  = '0;
                rx_bit_n   = rx_bit + 3'd1;
                rx_shift_n = {rx_s, rx_shift[7:1]};
                rx_state_n = rx_bit == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_baud == BAUD_LAST) begin
                rx_baud_n  = '0;
                rx_valid_n = rx_s;
                rx_last_n  = rx_s ? rx_shift : rx_last;
                rx_state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: begin
                rx_baud_n  = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_last  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s     <= rx_s1;
            rx_state <= rx_state_n;
            rx_baud  <= rx_baud_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_last  <= rx_last_n;
            rx_valid <= rx_valid_n;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed self-checking bench for uart_mmio with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_uart_mmio;
    logic        clk = 1'b0, rst_n = 1'b0, mem_wr = 1'b0, uart_rx = 1'b1;
    logic [9:0]  mem_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_hit, uart_tx, tx_busy, tx_overflow, rx_valid;
    int          passed = 0, failed = 0, total = 0, valid_cnt = 0, v0 = 0;
    logic [7:0]  burst [6];

    uart_mmio #(.ADDR_WIDTH(10), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_hit(rd_hit), .uart_tx(uart_tx),
        .uart_rx(uart_rx), .tx_busy(tx_busy), .tx_overflow(tx_overflow), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rx_valid === 1'b1) valid_cnt++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [9:0] a, input logic h, input logic [15:0] d, input string tag);
        mem_addr = a;
        step(1);
        check({tag, " rd_hit"}, 16'(rd_hit), 16'(h));
        check({tag, " rd_data"}, rd_data, d);
        mem_addr = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        mem_addr = a;
        wr_data  = d;
        mem_wr   = 1'b1;
        step(1);
        mem_wr   = 1'b0;
        mem_addr = '0;
    endtask

    task automatic tx_frame(input logic [7:0] b, input int first);
        for (int i = first; i < 10; i++) begin
            logic e;
            e = i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
            check($sformatf("tx %02h bit%0d head", b, i), 16'(uart_tx), 16'(e));
            step(3);
            check($sformatf("tx %02h bit%0d tail", b, i), 16'(uart_tx), 16'(e));
            step(1);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        step(4);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            step(4);
        end
        uart_rx = stop;
        step(4);
    endtask

    initial begin
        burst = '{8'h01, 8'h80, 8'ha5, 8'h3c, 8'hff, 8'h77};
        step(3);
        check("reset uart_tx", 16'(uart_tx), 16'h1);
        check("reset tx_busy", 16'(tx_busy), 16'h0);
        check("reset tx_overflow", 16'(tx_overflow), 16'h0);
        check("reset rx_valid", 16'(rx_valid), 16'h0);
        check("reset rd_hit", 16'(rd_hit), 16'h0);
        check("reset rd_data", rd_data, 16'h0000);
        rst_n = 1'b1;
        step(2);

        read_chk(10'h002, 1'b1, 16'hfe00, "rd 002");
        read_chk(10'h020, 1'b0, 16'h0000, "rd 020");
        read_chk(10'h003, 1'b1, 16'hfe00, "rd 003");
        read_chk(10'h004, 1'b0, 16'h0000, "rd 004");

        wr(10'h002, 16'h0041);
        step(1);
        check("single tx_busy", 16'(tx_busy), 16'h1);
        tx_frame(8'h41, 0);
        check("single busy after stop", 16'(tx_busy), 16'h0);
        check("single no overflow", 16'(tx_overflow), 16'h0);

        mem_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_addr = (i % 2 == 1) ? 10'h003 : 10'h002;
            wr_data  = {8'hab, burst[i]};
            step(1);
            if (i == 1) check("burst start bit", 16'(uart_tx), 16'h0);
        end
        mem_wr   = 1'b0;
        mem_addr = '0;
        check("burst overflow", 16'(tx_overflow), 16'h1);
        tx_frame(burst[0], 1);
        for (int i = 1; i < 5; i++) tx_frame(burst[i], 0);
        check("burst idle after 5", 16'(tx_busy), 16'h0);
        check("burst line idle", 16'(uart_tx), 16'h1);
        check("overflow sticky", 16'(tx_overflow), 16'h1);

        v0 = valid_cnt;
        rx_send(8'h5a, 1'b1);
        step(6);
        check("rx 5a valid pulses", 16'(valid_cnt - v0), 16'd1);
        read_chk(10'h002, 1'b1, 16'hfe5a, "rd after 5a");

        v0 = valid_cnt;
        rx_send(8'h33, 1'b0);
        step(20);
        uart_rx = 1'b1;
        step(8);
        check("framing err no valid", 16'(valid_cnt - v0), 16'd0);
        read_chk(10'h002, 1'b1, 16'hfe5a, "rd after framing err");
        v0 = valid_cnt;
        rx_send(8'h11, 1'b1);
        step(6);
        check("rx 11 valid pulses", 16'(valid_cnt - v0), 16'd1);
        read_chk(10'h003, 1'b1, 16'hfe11, "rd after 11");

        v0 = valid_cnt;
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        step(20);
        check("glitch no valid", 16'(valid_cnt - v0), 16'd0);
        read_chk(10'h002, 1'b1, 16'hfe11, "rd after glitch");

        wr(10'h002, 16'h0041);
        wr(10'h002, 16'h0042);
        check("pre-reset start bit", 16'(uart_tx), 16'h0);
        check("pre-reset busy", 16'(tx_busy), 16'h1);
        #3 rst_n = 1'b0;
        #1;
        check("async reset uart_tx", 16'(uart_tx), 16'h1);
        check("async reset busy", 16'(tx_busy), 16'h0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post-reset uart_tx", 16'(uart_tx), 16'h1);
        check("post-reset overflow", 16'(tx_overflow), 16'h0);
        step(30);
        check("post-reset fifo empty", 16'(tx_busy), 16'h0);
        check("post-reset line idle", 16'(uart_tx), 16'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral on the CPU data bus, decoding word address 002h-003h. It sits directly downstream of the CPU's mem_addr/mem_wr/wr_data outputs and feeds its rd_data input through the top-level read mux.
- Writes queue a byte into a TX FIFO, which is serialised as 8N1 on uart_tx.
- uart_rx is deserialised; the last good byte is returned on reads as {8'hfe, byte}.

Parameters:
- ADDR_WIDTH, 10: width of mem_addr; matches the CPU bus.
- BAUD_DIV, 234: clock cycles per UART bit (27 MHz / 115200). Legal range is 4 or more.
- FIFO_DEPTH, 16: TX FIFO entries. Must be a power of two, 2 or more.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  ADDR_WIDTH  CPU byte address.
- mem_wr  in  1  CPU write strobe; high for exactly one cycle per store.
- wr_data  in  16  CPU write data; only [7:0] is used.
- rd_data  out  16  registered read data for the top-level read mux.
- rd_hit  out  1  registered; high when rd_data carries UART data (address hit on the previous cycle).
- uart_tx  out  1  serial output; idle high.
- uart_rx  in  1  serial input; asynchronous to clk.
- tx_busy  out  1  high while the FIFO is non-empty or the TX FSM is not IDLE.
- tx_overflow  out  1  sticky; set when a write is dropped because the FIFO is full.
- rx_valid  out  1  one-cycle pulse when rx_last is updated.

Behaviour:
- **Address decode.** hit = (mem_addr[ADDR_WIDTH-1:1] == 1), i.e. 002h or 003h. Combinational, used internally only.
- **Reset values.** rd_data=0, rd_hit=0, uart_tx=1, tx_busy=0, tx_overflow=0, rx_valid=0, rx_last=8'h00, FIFO empty, both FSMs IDLE, all counters 0.
- **Read path.**
  - Every cycle: rd_hit <= hit; rd_data <= hit ? {8'hfe, rx_last} : 16'h0000.
  - Latency is 1 cycle. Reads have no side effects.
  - A byte read of 003h yields 8'hfe through the CPU's byte formatting; this is intentional.
- **Write path.**
  - When mem_wr && hit, wr_data[7:0] is pushed.
  - The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and tx_overflow <= 1. tx_overflow clears only on reset.
  - Addresses 002h and 003h behave identically.
- **TX FSM** (states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..BAUD_DIV-1):
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START. uart_tx goes low on the following edge, so a write to an empty, idle block at cycle N drives uart_tx=0 from edge N+2.
  - START, DATA, STOP each hold their bit for exactly BAUD_DIV cycles. DATA sends LSB first, 8 bits. STOP drives 1.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START (no extra idle cycles); else go to IDLE.
  - uart_tx is driven from a register; no glitches.
- **RX path.**
  - uart_rx passes through a 2-flop synchroniser (rx_s) before use.
  - The RX FSM has states IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: go to START when rx_s == 0.
  - START: wait BAUD_DIV/2 (integer division) cycles and resample. If rx_s == 1, treat as a false start and return to IDLE; else go to DATA.
  - DATA: sample every BAUD_DIV cycles, 8 bits, LSB first into the shift register.
  - STOP: sample after BAUD_DIV cycles.
    - If rx_s == 1: rx_last <= shift register, rx_valid = 1 for one cycle, go to IDLE.
    - If rx_s == 0 (framing error): discard the byte, leave rx_last unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE when rx_s == 1.
  - rx_last updates take effect on rd_data only at the next read hit. A read in the same cycle as the update returns the old value.
- **Simultaneous events.**
  - A push and a pop in the same cycle keep count unchanged.
  - A push at full with a simultaneous pop is accepted.
  - TX and RX are fully independent.
- **Reset mid-frame.** Asserting rst_n low forces uart_tx=1 immediately (asynchronously), flushes the FIFO and discards any partial RX byte.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4):
1. Reset, then read 002h → next cycle rd_hit=1 and rd_data=16'hfe00; read 020h → rd_hit=0 and rd_data=0.
2. Write 16'h0041 to 002h at cycle N → uart_tx=0 over cycles N+2..N+5, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop=1; tx_busy falls after the stop bit.
3. Write 6 bytes back-to-back while idle → 1 popped to the shifter plus 4 queued; the 6th is dropped, tx_overflow=1, and exactly 5 frames appear on uart_tx with no gap between stop and start bits.
4. Drive an 8N1 frame of 8'h5a on uart_rx → rx_valid pulses once; a subsequent read of 002h returns 16'hfe5a.
5. Drive a frame of 8'h33 whose stop bit is 0, then hold the line low for 20 cycles, then high, then send a valid 8'h11 → the first frame is discarded (rx_last stays 5a, no rx_valid); 8'h11 is received correctly.
6. Pulse uart_rx low for 1 cycle (glitch) → rejected as a false start, no rx_valid. Separately, assert rst_n mid-TX-frame → uart_tx=1 at once, FIFO empty, and tx_overflow=0 after release.
